// File: rtl/pico_io_hub_if.sv
// ---------------------------------------------------------------------------
// pico_io_hub_if
// KCPSM3 port bus as seen by the I/O hub.
//   port_id      : port address driven by the processor
//   write_strobe : one-cycle output strobe
//   read_strobe  : one-cycle input strobe
//   out_port     : processor write data
//   in_port      : read data returned to the processor
// Modports: master = processor side, slave = hub side.
// ---------------------------------------------------------------------------
interface pico_io_hub_if #(
    parameter int DW = 8
);
    logic [7:0]    port_id;
    logic          write_strobe;
    logic          read_strobe;
    logic [DW-1:0] out_port;
    logic [DW-1:0] in_port;

    modport master (
        output port_id, write_strobe, read_strobe, out_port,
        input  in_port
    );

    modport slave (
        input  port_id, write_strobe, read_strobe, out_port,
        output in_port
    );
endinterface

// File: rtl/pico_io_hub.sv
// ---------------------------------------------------------------------------
// pico_io_hub
// Reusable KCPSM3 I/O hub: readback-able output register bank, sticky event
// flags with masked interrupt, UART FIFO strobes and a sequential shift-add
// multiplier.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous, active-low
//   bus       : KCPSM3 port bus (slave modport)
//   sw        : switch inputs, read unregistered at 0x15
//   evt       : event pulses setting the sticky flags
//   out_regs  : flattened output registers, reg k at [k*DW +: DW]
//   tx_wr     : UART write pulse (write to 0x10)
//   tx_full   : UART tx FIFO full
//   rx_rd     : UART read pulse (read strobe at 0x11)
//   rx_empty  : UART rx FIFO empty
//   rx_data   : UART rx FIFO head
//   irq       : registered |(flags & irq_mask)
//
// Multiplier FSM:
//   state  | meaning
//   S_IDLE | waiting for a start write to 0x12
//   S_RUN  | DW shift-add steps in progress, busy=1
// ---------------------------------------------------------------------------
module pico_io_hub #(
    parameter int DW     = 8,
    parameter int N_OUT  = 4,
    parameter int N_FLAG = 4
) (
    input  logic              clk,
    input  logic              reset,
    pico_io_hub_if.slave      bus,
    input  logic [DW-1:0]     sw,
    input  logic [N_FLAG-1:0] evt,
    output logic [N_OUT*DW-1:0] out_regs,
    output logic              tx_wr,
    input  logic              tx_full,
    output logic              rx_rd,
    input  logic              rx_empty,
    input  logic [DW-1:0]     rx_data,
    output logic              irq
);

    localparam logic [7:0] ID_TX     = 8'h10;
    localparam logic [7:0] ID_MULT_A = 8'h11;
    localparam logic [7:0] ID_MULT_B = 8'h12;
    localparam logic [7:0] ID_CLR    = 8'h13;
    localparam logic [7:0] ID_MASK   = 8'h14;
    localparam logic [7:0] ID_STATUS = 8'h10;
    localparam logic [7:0] ID_RX     = 8'h11;
    localparam logic [7:0] ID_FLAGS  = 8'h12;
    localparam logic [7:0] ID_PLO    = 8'h13;
    localparam logic [7:0] ID_PHI    = 8'h14;
    localparam logic [7:0] ID_SW     = 8'h15;
    localparam int         CW        = $clog2(DW + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    logic [N_OUT*DW-1:0] r_out_regs;
    logic [N_FLAG-1:0]   r_flags;
    logic [N_FLAG-1:0]   r_irq_mask;
    logic                r_irq;
    state_t              r_state;
    logic [DW-1:0]       r_mult_a;
    logic [DW-1:0]       r_mcand;
    logic [2*DW-1:0]     r_acc;
    logic [CW-1:0]       r_count;
    logic [2*DW-1:0]     r_product;
    logic                r_busy;
    logic                r_done;

    logic                w_wr_a;
    logic                w_wr_b;
    logic                w_rd_hi;
    logic [N_FLAG-1:0]   w_clr;
    logic [DW:0]         w_sum;
    logic [2*DW-1:0]     w_acc_next;
    logic [DW-1:0]       w_rd_data;

    assign tx_wr   = bus.write_strobe && (bus.port_id == ID_TX);
    assign rx_rd   = bus.read_strobe  && (bus.port_id == ID_RX);
    assign w_wr_a  = bus.write_strobe && (bus.port_id == ID_MULT_A);
    assign w_wr_b  = bus.write_strobe && (bus.port_id == ID_MULT_B);
    assign w_rd_hi = bus.read_strobe  && (bus.port_id == ID_PHI);
    assign w_clr   = (bus.write_strobe && (bus.port_id == ID_CLR)) ?
                     bus.out_port[N_FLAG-1:0] : '0;

    // The multiplier lives in the low half of the accumulator: each step adds
    // into the upper half and the whole word shifts right, so the next
    // multiplier bit is always at bit 0.
    assign w_sum      = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next = {w_sum, r_acc[DW-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_regs <= '0;
        end else if (bus.write_strobe) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (bus.port_id == 8'(k)) begin
                    r_out_regs[k*DW +: DW] <= bus.out_port;
                end
            end
        end
    end

    // OR-ing evt after the clear makes a same-cycle set win over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags    <= '0;
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_flags <= (r_flags & ~w_clr) | evt;
            if (bus.write_strobe && (bus.port_id == ID_MASK)) begin
                r_irq_mask <= bus.out_port[N_FLAG-1:0];
            end
            r_irq <= |(r_flags & r_irq_mask);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_mult_a  <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_a) begin
                        r_mult_a <= bus.out_port;
                    end
                    // A start overrides a same-cycle done clear.
                    if (w_wr_b) begin
                        r_mcand <= r_mult_a;
                        r_acc   <= {{DW{1'b0}}, bus.out_port};
                        r_count <= CW'(DW);
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_RUN;
                    end else if (w_rd_hi) begin
                        r_done <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_product <= w_acc_next;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (bus.port_id == 8'(k)) begin
                w_rd_data = r_out_regs[k*DW +: DW];
            end
        end
        case (bus.port_id)
            ID_STATUS: w_rd_data = DW'({tx_full, ~rx_empty, r_busy, r_done});
            ID_RX:     w_rd_data = rx_data;
            ID_FLAGS:  w_rd_data = DW'(r_flags);
            ID_PLO:    w_rd_data = r_product[DW-1:0];
            ID_PHI:    w_rd_data = r_product[2*DW-1:DW];
            ID_SW:     w_rd_data = sw;
            default:   ;
        endcase
    end

    assign bus.in_port = w_rd_data;
    assign out_regs    = r_out_regs;
    assign irq         = r_irq;

endmodule

// File: tb/tb_pico_io_hub.sv
module tb_pico_io_hub;
    localparam int DW     = 8;
    localparam int N_OUT  = 4;
    localparam int N_FLAG = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pico_io_hub_if #(.DW(DW)) bus ();

    logic [DW-1:0]       sw;
    logic [DW-1:0]       rx_data;
    logic [N_FLAG-1:0]   evt;
    logic [N_OUT*DW-1:0] out_regs;
    logic                tx_wr;
    logic                tx_full;
    logic                rx_rd;
    logic                rx_empty;
    logic                irq;

    pico_io_hub #(.DW(DW), .N_OUT(N_OUT), .N_FLAG(N_FLAG)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .bus      (bus),
        .sw       (sw),
        .evt      (evt),
        .out_regs (out_regs),
        .tx_wr    (tx_wr),
        .tx_full  (tx_full),
        .rx_rd    (rx_rd),
        .rx_empty (rx_empty),
        .rx_data  (rx_data),
        .irq      (irq)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       ws;
        logic       rs;
        logic [7:0] id;
        logic [7:0] d;
        logic [3:0] e;
        logic [7:0] x_in;
        logic       x_tx;
        logic       x_rx;
        logic       x_irq;
    } vec_t;

    vec_t tv[$];

    // reference model state
    logic [7:0]  m_out[N_OUT];
    logic [3:0]  m_flags, m_mask;
    logic        m_irq, m_busy, m_done;
    logic [7:0]  m_ma, m_pa, m_pb;
    logic [15:0] m_prod;
    int          m_rem;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ws, input logic rs, input logic [7:0] id,
                         input logic [7:0] d, input logic [3:0] e);
        bus.write_strobe = ws;
        bus.read_strobe  = rs;
        bus.port_id      = id;
        bus.out_port     = d;
        evt              = e;
    endtask

    task automatic idle_bus();
        drive(1'b0, 1'b0, 8'hFF, 8'h00, 4'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        drive(1'b1, 1'b0, id, d, 4'h0);
        step();
        idle_bus();
    endtask

    task automatic rd(input logic [7:0] id, output logic [7:0] d);
        drive(1'b0, 1'b1, id, 8'h00, 4'h0);
        #1 d = bus.in_port;
        step();
        idle_bus();
    endtask

    task automatic peek(input logic [7:0] id, output logic [7:0] d);
        drive(1'b0, 1'b0, id, 8'h00, 4'h0);
        #1 d = bus.in_port;
        step();
        idle_bus();
    endtask

    task automatic mul_check(input logic [7:0] a, input logic [7:0] b);
        logic [7:0]  lo, hi;
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        wr(8'h11, a);
        wr(8'h12, b);
        repeat (DW + 2) step();
        peek(8'h13, lo);
        peek(8'h14, hi);
        chk("mul_product", {16'h0, hi, lo}, {16'h0, p});
    endtask

    function automatic void add(input logic ws, input logic rs, input logic [7:0] id,
                                input logic [7:0] d, input logic [3:0] e, input logic [7:0] x_in,
                                input logic x_tx, input logic x_rx, input logic x_irq);
        vec_t v;
        v.ws = ws; v.rs = rs; v.id = id; v.d = d; v.e = e;
        v.x_in = x_in; v.x_tx = x_tx; v.x_rx = x_rx; v.x_irq = x_irq;
        tv.push_back(v);
    endfunction

    function automatic logic [7:0] model_rd(input logic [7:0] id);
        logic [7:0] r;
        r = 8'h00;
        if (id < 8'(N_OUT)) r = m_out[id[1:0]];
        else if (id == 8'h10) r = {4'h0, tx_full, ~rx_empty, m_busy, m_done};
        else if (id == 8'h11) r = rx_data;
        else if (id == 8'h12) r = {4'h0, m_flags};
        else if (id == 8'h13) r = m_prod[7:0];
        else if (id == 8'h14) r = m_prod[15:8];
        else if (id == 8'h15) r = sw;
        return r;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < N_OUT; k++) m_out[k] = 8'h00;
        m_flags = 4'h0; m_mask = 4'h0; m_irq = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
        m_ma = 8'h00; m_pa = 8'h00; m_pb = 8'h00; m_prod = 16'h0;
    endfunction

    function automatic void model_edge(input logic ws, input logic rs, input logic [7:0] id,
                                       input logic [7:0] d, input logic [3:0] e);
        logic n_irq;
        logic [3:0] clr;
        n_irq = |(m_flags & m_mask);
        if (ws && id < 8'(N_OUT)) m_out[id[1:0]] = d;
        clr = (ws && id == 8'h13) ? d[3:0] : 4'h0;
        m_flags = (m_flags & ~clr) | e;
        if (ws && id == 8'h14) m_mask = d[3:0];
        if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_prod = 16'(m_pa) * 16'(m_pb);
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else begin
            if (rs && id == 8'h14) m_done = 1'b0;
            if (ws && id == 8'h11) m_ma = d;
            if (ws && id == 8'h12) begin
                m_pa = m_ma; m_pb = d; m_busy = 1'b1; m_rem = DW; m_done = 1'b0;
            end
        end
        m_irq = n_irq;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] st, v;
        int busy_cnt;
        logic [7:0] ids[11] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h10,
                                8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

        idle_bus();
        tx_full = 1'b0; rx_empty = 1'b0; rx_data = 8'h41; sw = 8'h3C;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // traffic, then reset mid-stream
        wr(8'h01, 8'h77);
        wr(8'h14, 8'h01);
        drive(1'b0, 1'b0, 8'hFF, 8'h00, 4'h1);
        step();
        idle_bus();
        step();
        chk("irq_before_reset", {31'h0, irq}, 32'h1);
        chk("out_before_reset", out_regs, 32'h0000_7700);
        rst_n = 1'b0;
        #1;
        chk("reset_out_regs", out_regs, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // ws rs id d evt | in_port tx_wr rx_rd irq
        add(0, 0, 8'h10, 8'h00, 4'h0, 8'h04, 0, 0, 0);
        add(1, 0, 8'h02, 8'hA5, 4'h0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h02, 8'h00, 4'h0, 8'hA5, 0, 0, 0);
        add(1, 0, 8'h07, 8'h55, 4'h0, 8'h00, 0, 0, 0);
        add(0, 0, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 0);
        add(0, 0, 8'h01, 8'h00, 4'h0, 8'h00, 0, 0, 0);
        add(0, 0, 8'h03, 8'h00, 4'h0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h11, 8'h00, 4'h0, 8'h41, 0, 1, 0);
        add(0, 0, 8'h11, 8'h00, 4'h0, 8'h41, 0, 0, 0);
        add(1, 0, 8'h10, 8'h5A, 4'h0, 8'h04, 1, 0, 0);
        add(0, 0, 8'h10, 8'h00, 4'h0, 8'h04, 0, 0, 0);
        add(0, 0, 8'h15, 8'h00, 4'h0, 8'h3C, 0, 0, 0);
        add(0, 0, 8'h12, 8'h00, 4'h2, 8'h00, 0, 0, 0);
        add(0, 0, 8'h12, 8'h00, 4'h0, 8'h02, 0, 0, 0);
        add(1, 0, 8'h14, 8'h02, 4'h0, 8'h00, 0, 0, 0);
        add(0, 0, 8'h12, 8'h00, 4'h0, 8'h02, 0, 0, 0);
        add(1, 0, 8'h13, 8'h02, 4'h2, 8'h00, 0, 0, 1);
        add(0, 0, 8'h12, 8'h00, 4'h0, 8'h02, 0, 0, 1);
        add(1, 0, 8'h13, 8'h02, 4'h0, 8'h00, 0, 0, 1);
        add(0, 0, 8'h12, 8'h00, 4'h0, 8'h00, 0, 0, 1);
        add(0, 0, 8'h12, 8'h00, 4'h0, 8'h00, 0, 0, 0);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].ws, tv[i].rs, tv[i].id, tv[i].d, tv[i].e);
            #1;
            chk($sformatf("vec%0d_in_port", i), {24'h0, bus.in_port}, {24'h0, tv[i].x_in});
            chk($sformatf("vec%0d_tx_wr", i), {31'h0, tx_wr}, {31'h0, tv[i].x_tx});
            chk($sformatf("vec%0d_rx_rd", i), {31'h0, rx_rd}, {31'h0, tv[i].x_rx});
            chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, tv[i].x_irq});
            step();
        end
        idle_bus();
        chk("out_regs_after_vec", out_regs, 32'h00A5_0000);

        // multiplier 0xFF x 0xFF with an ignored mult_a write while busy
        wr(8'h11, 8'hFF);
        wr(8'h12, 8'hFF);
        wr(8'h11, 8'h03);
        busy_cnt = 1;
        st = 8'h00;
        for (int i = 0; i < 20; i++) begin
            peek(8'h10, st);
            if (st[1]) busy_cnt++;
            else break;
        end
        chk("busy_cycles", busy_cnt, 8);
        chk("status_done", {24'h0, st}, 32'h05);
        peek(8'h13, v);
        chk("ffxff_lo", {24'h0, v}, 32'h01);
        rd(8'h14, v);
        chk("ffxff_hi", {24'h0, v}, 32'hFE);
        peek(8'h10, v);
        chk("done_cleared", {24'h0, v}, 32'h04);

        // mult_a must still be 0xFF; product holds old value during RUN
        wr(8'h12, 8'h02);
        peek(8'h13, v);
        chk("prod_held_in_run", {24'h0, v}, 32'h01);
        repeat (10) step();
        peek(8'h13, v);
        chk("ffx02_lo", {24'h0, v}, 32'hFE);
        peek(8'h14, v);
        chk("ffx02_hi", {24'h0, v}, 32'h01);

        mul_check(8'h00, 8'h37);
        mul_check(8'h80, 8'h02);
        mul_check(8'h0D, 8'hB3);

        // reset in RUN cycle 4
        wr(8'h11, 8'h37);
        wr(8'h12, 8'h05);
        repeat (3) step();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h10, 8'h00, 4'h0);
        #1 chk("rst_run_status", {24'h0, bus.in_port}, 32'h04);
        bus.port_id = 8'h13;
        #1 chk("rst_run_prod_lo", {24'h0, bus.in_port}, 32'h00);
        bus.port_id = 8'h14;
        #1 chk("rst_run_prod_hi", {24'h0, bus.in_port}, 32'h00);
        step();
        rst_n = 1'b1;
        idle_bus();
        repeat (12) step();
        peek(8'h10, v);
        chk("rst_run_no_done", {24'h0, v}, 32'h04);

        // randomized traffic against the reference model
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        model_reset();
        for (int i = 0; i < 600; i++) begin
            logic       ws, rs;
            logic [7:0] id, d;
            logic [3:0] e;
            int op;
            op = $urandom_range(0, 4);
            ws = (op == 1 || op == 2);
            rs = (op == 3);
            id = ids[$urandom_range(0, 10)];
            if ($urandom_range(0, 9) == 0) id = 8'($urandom_range(0, 255));
            d  = 8'($urandom_range(0, 255));
            e  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            tx_full  = 1'($urandom_range(0, 1));
            rx_empty = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom_range(0, 255));
            sw       = 8'($urandom_range(0, 255));
            drive(ws, rs, id, d, e);
            #1;
            chk("rnd_in_port", {24'h0, bus.in_port}, {24'h0, model_rd(id)});
            chk("rnd_tx_wr", {31'h0, tx_wr}, {31'h0, ws && id == 8'h10});
            chk("rnd_rx_rd", {31'h0, rx_rd}, {31'h0, rs && id == 8'h11});
            chk("rnd_irq", {31'h0, irq}, {31'h0, m_irq});
            chk("rnd_out_regs", out_regs, {m_out[3], m_out[2], m_out[1], m_out[0]});
            model_edge(ws, rs, id, d, e);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
